// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath:
// opcode/status inputs from the datapath, select and enable lines back to it.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       mem_ready;
  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       ext_zero;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, alu_zero, mem_ready,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, ext_zero, pc_source,
           illegal_op, state
  );

  modport slave (
    output opcode, alu_zero, mem_ready,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, ext_zero, pc_source,
           illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle MIPS-subset datapath. Moore outputs are
// registered from the next state; only ir_write/pc_write carry input terms.
module multicycle_control (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    st_reset     = 4'd0,
    st_fetch     = 4'd1,
    st_decode    = 4'd2,
    st_mem_addr  = 4'd3,
    st_mem_read  = 4'd4,
    st_mem_wb    = 4'd5,
    st_mem_write = 4'd6,
    st_r_exec    = 4'd7,
    st_r_wb      = 4'd8,
    st_i_exec    = 4'd9,
    st_i_wb      = 4'd10,
    st_branch    = 4'd11,
    st_jump      = 4'd12,
    st_jal       = 4'd13,
    st_halt      = 4'd15
  } state_t;

  localparam logic [5:0] op_r    = 6'b000000;
  localparam logic [5:0] op_lw   = 6'b100011;
  localparam logic [5:0] op_sw   = 6'b101011;
  localparam logic [5:0] op_beq  = 6'b000100;
  localparam logic [5:0] op_bne  = 6'b000101;
  localparam logic [5:0] op_j    = 6'b000010;
  localparam logic [5:0] op_jal  = 6'b000011;
  localparam logic [5:0] op_addi = 6'b001000;
  localparam logic [5:0] op_slti = 6'b001010;
  localparam logic [5:0] op_andi = 6'b001100;
  localparam logic [5:0] op_ori  = 6'b001101;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl_reg;

  // Moore output pattern for a state; pc_write in FETCH/BRANCH is added outside.
  function automatic ctrl_t decode(input state_t s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      st_fetch: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      st_decode:    c.alu_src_b = 2'b11;
      st_mem_addr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      st_mem_read: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      st_mem_wb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'b01;
      end
      st_mem_write: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      st_r_exec: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      st_r_wb: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 2'b01;
      end
      st_i_exec: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b11;
        c.ext_zero  = (op == op_andi) || (op == op_ori);
      end
      st_i_wb:      c.reg_write = 1'b1;
      st_branch: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_source = 2'b01;
      end
      st_jump: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      st_jal: begin
        c.pc_write   = 1'b1;
        c.pc_source  = 2'b10;
        c.reg_write  = 1'b1;
        c.reg_dst    = 2'b10;
        c.mem_to_reg = 2'b10;
      end
      st_halt:      c.illegal_op = 1'b1;
      default:      c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_next = st_halt;
    case (state_reg)
      st_reset:     state_next = st_fetch;
      st_fetch:     state_next = bus.mem_ready ? st_decode : st_fetch;
      st_decode: begin
        case (bus.opcode)
          op_lw, op_sw:                     state_next = st_mem_addr;
          op_r:                             state_next = st_r_exec;
          op_addi, op_slti, op_andi, op_ori: state_next = st_i_exec;
          op_beq, op_bne:                   state_next = st_branch;
          op_j:                             state_next = st_jump;
          op_jal:                           state_next = st_jal;
          default:                          state_next = st_halt;
        endcase
      end
      st_mem_addr:  state_next = (bus.opcode == op_sw) ? st_mem_write : st_mem_read;
      st_mem_read:  state_next = bus.mem_ready ? st_mem_wb : st_mem_read;
      st_mem_wb:    state_next = st_fetch;
      st_mem_write: state_next = bus.mem_ready ? st_fetch : st_mem_write;
      st_r_exec:    state_next = st_r_wb;
      st_r_wb:      state_next = st_fetch;
      st_i_exec:    state_next = st_i_wb;
      st_i_wb:      state_next = st_fetch;
      st_branch:    state_next = st_fetch;
      st_jump:      state_next = st_fetch;
      st_jal:       state_next = st_fetch;
      default:      state_next = st_halt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= st_reset;
      ctrl_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= decode(state_next, bus.opcode);
    end
  end

  logic fetch_done;
  logic branch_taken;
  assign fetch_done   = (state_reg == st_fetch) && bus.mem_ready;
  assign branch_taken = (state_reg == st_branch) &&
                        (((bus.opcode == op_beq) && bus.alu_zero) ||
                         ((bus.opcode == op_bne) && !bus.alu_zero));

  assign bus.pc_write   = ctrl_reg.pc_write | fetch_done | branch_taken;
  assign bus.ir_write   = fetch_done;
  assign bus.iord       = ctrl_reg.iord;
  assign bus.mem_read   = ctrl_reg.mem_read;
  assign bus.mem_write  = ctrl_reg.mem_write;
  assign bus.reg_dst    = ctrl_reg.reg_dst;
  assign bus.mem_to_reg = ctrl_reg.mem_to_reg;
  assign bus.reg_write  = ctrl_reg.reg_write;
  assign bus.alu_src_a  = ctrl_reg.alu_src_a;
  assign bus.alu_src_b  = ctrl_reg.alu_src_b;
  assign bus.alu_op     = ctrl_reg.alu_op;
  assign bus.ext_zero   = ctrl_reg.ext_zero;
  assign bus.pc_source  = ctrl_reg.pc_source;
  assign bus.illegal_op = ctrl_reg.illegal_op;
  assign bus.state      = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: expands each instruction into its expected
// per-cycle trace and compares every DUT output against it.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;
  } obs_t;

  typedef struct {
    logic [5:0] opcode;
    logic       mem_ready;
    logic       alu_zero;
    obs_t       exp;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  int   n_reg_write, n_mem_write, n_wr_txn, n_illegal, n_pc_write;
  cyc_t q[$];

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t blank(input int st);
    obs_t o;
    o = '0;
    o.state = st[3:0];
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.pc_write   = bus.pc_write;
    o.iord       = bus.iord;
    o.mem_read   = bus.mem_read;
    o.mem_write  = bus.mem_write;
    o.ir_write   = bus.ir_write;
    o.reg_dst    = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg;
    o.reg_write  = bus.reg_write;
    o.alu_src_a  = bus.alu_src_a;
    o.alu_src_b  = bus.alu_src_b;
    o.alu_op     = bus.alu_op;
    o.ext_zero   = bus.ext_zero;
    o.pc_source  = bus.pc_source;
    o.illegal_op = bus.illegal_op;
    o.state      = bus.state;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic push(input logic [5:0] op, input logic rdy, input logic az, input obs_t o);
    cyc_t c;
    c.opcode = op; c.mem_ready = rdy; c.alu_zero = az; c.exp = o;
    q.push_back(c);
  endtask

  // Fetch cycles only; the last one completes when complete=1.
  task automatic add_fetch(input logic [5:0] op, input int waits, input logic complete);
    obs_t o;
    for (int i = 0; i <= waits; i++) begin
      logic rdy;
      rdy = complete && (i == waits);
      o = blank(1); o.mem_read = 1; o.alu_src_b = 2'b01;
      o.ir_write = rdy; o.pc_write = rdy;
      push(op, rdy, 1'b0, o);
    end
  endtask

  // Model: whole instruction as a list of expected cycles.
  task automatic add_instr(input logic [5:0] op, input int fwait, input int mwait,
                           input logic az, input int halt_cycles);
    obs_t o;
    add_fetch(op, fwait, 1'b1);
    o = blank(2); o.alu_src_b = 2'b11; push(op, 1'b0, az, o);
    if (op == OP_LW || op == OP_SW) begin
      o = blank(3); o.alu_src_a = 1; o.alu_src_b = 2'b10; push(op, 1'b0, az, o);
      for (int i = 0; i <= mwait; i++) begin
        o = blank(op == OP_LW ? 4 : 6); o.iord = 1;
        if (op == OP_LW) o.mem_read = 1; else o.mem_write = 1;
        push(op, i == mwait, az, o);
      end
      if (op == OP_LW) begin
        o = blank(5); o.reg_write = 1; o.mem_to_reg = 2'b01; push(op, 1'b0, az, o);
      end
    end else if (op == OP_R) begin
      o = blank(7); o.alu_src_a = 1; o.alu_op = 2'b10; push(op, 1'b0, az, o);
      o = blank(8); o.reg_write = 1; o.reg_dst = 2'b01; push(op, 1'b0, az, o);
    end else if (op == OP_ADDI || op == OP_SLTI || op == OP_ANDI || op == OP_ORI) begin
      o = blank(9); o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 2'b11;
      o.ext_zero = (op == OP_ANDI || op == OP_ORI); push(op, 1'b0, az, o);
      o = blank(10); o.reg_write = 1; push(op, 1'b0, az, o);
    end else if (op == OP_BEQ || op == OP_BNE) begin
      o = blank(11); o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01;
      o.pc_write = (op == OP_BEQ) ? az : !az; push(op, 1'b0, az, o);
    end else if (op == OP_J) begin
      o = blank(12); o.pc_write = 1; o.pc_source = 2'b10; push(op, 1'b0, az, o);
    end else if (op == OP_JAL) begin
      o = blank(13); o.pc_write = 1; o.pc_source = 2'b10; o.reg_write = 1;
      o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; push(op, 1'b0, az, o);
    end else begin
      for (int i = 0; i < halt_cycles; i++) begin
        o = blank(15); o.illegal_op = 1; push(op, 1'b1, az, o);
      end
    end
  endtask

  // The single compare process: one expected cycle per negedge.
  task automatic run_queue();
    cyc_t c;
    obs_t got;
    n_reg_write = 0; n_mem_write = 0; n_wr_txn = 0; n_illegal = 0; n_pc_write = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      bus.opcode = c.opcode; bus.mem_ready = c.mem_ready; bus.alu_zero = c.alu_zero;
      #1;
      got = observe();
      cyc_no++;
      n_reg_write += int'(got.reg_write);
      n_mem_write += int'(got.mem_write);
      n_wr_txn    += int'(got.mem_write & c.mem_ready);
      n_illegal   += int'(got.illegal_op);
      n_pc_write  += int'(got.pc_write);
      checks++;
      if (got !== c.exp) begin
        errors++;
        $display("FAIL cycle %0d state %0d: got %h required %h", cyc_no, c.exp.state, got, c.exp);
      end else begin
        $display("cycle %0d state %0d op %b rdy %b outputs %h", cyc_no, got.state, c.opcode, c.mem_ready, got);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_assert_outputs", 32'(observe()), 32'(blank(0)));
    repeat (2) @(negedge clk);
    bus.opcode = '0; bus.mem_ready = 1'b0; bus.alu_zero = 1'b0;
    rst_n = 1'b1;
    #1;
    check("reset_release_cycle", 32'(observe()), 32'(blank(0)));
  endtask

  initial begin
    bus.opcode = '0; bus.mem_ready = 1'b0; bus.alu_zero = 1'b0;
    do_reset();

    add_instr(OP_LW, 0, 0, 1'b0, 0);
    check("lw_cycles", q.size(), 5);
    run_queue();
    check("lw_reg_write_count", n_reg_write, 1);

    add_instr(OP_SW, 0, 3, 1'b0, 0);
    check("sw_cycles", q.size(), 7);
    run_queue();
    check("sw_mem_write_cycles", n_mem_write, 4);
    check("sw_write_txns", n_wr_txn, 1);
    check("sw_no_reg_write", n_reg_write, 0);

    add_instr(OP_BEQ, 0, 0, 1'b1, 0);
    check("beq_cycles", q.size(), 3);
    run_queue();
    check("beq_taken_pc_writes", n_pc_write, 2);

    add_instr(OP_BNE, 0, 0, 1'b1, 0);
    check("bne_cycles", q.size(), 3);
    run_queue();
    check("bne_not_taken_pc_writes", n_pc_write, 1);

    add_instr(OP_BNE, 0, 0, 1'b0, 0);
    add_instr(OP_BEQ, 0, 0, 1'b0, 0);
    run_queue();

    add_instr(OP_JAL, 0, 0, 1'b0, 0);
    check("jal_cycles", q.size(), 3);
    run_queue();
    check("jal_reg_write_count", n_reg_write, 1);

    add_instr(OP_J, 0, 0, 1'b0, 0);
    add_instr(OP_R, 2, 0, 1'b0, 0);
    check("j_plus_r_fetchwait_cycles", q.size(), 3 + 6);
    run_queue();

    add_instr(OP_ORI, 0, 0, 1'b0, 0);
    add_instr(OP_ADDI, 0, 0, 1'b0, 0);
    add_instr(OP_ANDI, 0, 0, 1'b0, 0);
    add_instr(OP_SLTI, 0, 0, 1'b0, 0);
    check("itype_cycles", q.size(), 16);
    run_queue();

    add_instr(OP_LW, 1, 2, 1'b0, 0);
    check("lw_waits_cycles", q.size(), 8);
    run_queue();

    add_instr(OP_BAD, 0, 0, 1'b0, 22);
    run_queue();
    check("halt_illegal_cycles", n_illegal, 22);

    do_reset();
    add_fetch(OP_J, 3, 1'b0);
    run_queue();
    do_reset();

    add_instr(OP_J, 0, 0, 1'b0, 0);
    add_instr(OP_LW, 0, 1, 1'b0, 0);
    run_queue();
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
